// File: rtl/softmax_engine.sv
// softmax_engine: streaming softmax over a word range of three identical
// read-only memories. Each word holds NUM signed Q8.8 lanes.
//   Pass 1 (MAX)    : reads inp, tracks the running maximum.
//   Pass 2 (EXPSUM) : reads sub0_inp, accumulates exp(x - max).
//   LOG             : ln of the accumulated sum.
//   Pass 3 (NORM)   : reads sub1_inp, emits exp(x - max - ln(sum)).
// Ports:
//   clk, reset (sync, active high), init (sync clear, same effect as reset)
//   start          : one-cycle pulse, honoured only when idle
//   start_addr/end_addr : inclusive word range
//   inp/sub0_inp/sub1_inp : combinational read data for addr/sub0_inp_addr/sub1_inp_addr
//   outp0..outp3   : per-lane result, Q8.8
//   done           : set with the last word's results, held until reset/init
module softmax_engine #(
   parameter int DATAWIDTH = 16,
   parameter int NUM       = 4,
   parameter int ADDRSIZE  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      init,
   input  logic                      start,
   input  logic [ADDRSIZE-1:0]       start_addr,
   input  logic [ADDRSIZE-1:0]       end_addr,
   input  logic [DATAWIDTH*NUM-1:0]  inp,
   input  logic [DATAWIDTH*NUM-1:0]  sub0_inp,
   input  logic [DATAWIDTH*NUM-1:0]  sub1_inp,
   output logic [ADDRSIZE-1:0]       addr,
   output logic [ADDRSIZE-1:0]       sub0_inp_addr,
   output logic [ADDRSIZE-1:0]       sub1_inp_addr,
   output logic [DATAWIDTH-1:0]      outp0,
   output logic [DATAWIDTH-1:0]      outp1,
   output logic [DATAWIDTH-1:0]      outp2,
   output logic [DATAWIDTH-1:0]      outp3,
   output logic                      done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MAX    = 3'd1,
      S_EXPSUM = 3'd2,
      S_LOG    = 3'd3,
      S_NORM   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // 2^(i/32) in Q.16
   function automatic logic [31:0] exp2_lut(input logic [4:0] i);
      case (i)
         5'd0:  exp2_lut = 32'd65536;   5'd1:  exp2_lut = 32'd66971;
         5'd2:  exp2_lut = 32'd68438;   5'd3:  exp2_lut = 32'd69936;
         5'd4:  exp2_lut = 32'd71468;   5'd5:  exp2_lut = 32'd73032;
         5'd6:  exp2_lut = 32'd74632;   5'd7:  exp2_lut = 32'd76266;
         5'd8:  exp2_lut = 32'd77936;   5'd9:  exp2_lut = 32'd79642;
         5'd10: exp2_lut = 32'd81386;   5'd11: exp2_lut = 32'd83169;
         5'd12: exp2_lut = 32'd84990;   5'd13: exp2_lut = 32'd86851;
         5'd14: exp2_lut = 32'd88752;   5'd15: exp2_lut = 32'd90696;
         5'd16: exp2_lut = 32'd92682;   5'd17: exp2_lut = 32'd94711;
         5'd18: exp2_lut = 32'd96785;   5'd19: exp2_lut = 32'd98905;
         5'd20: exp2_lut = 32'd101070;  5'd21: exp2_lut = 32'd103284;
         5'd22: exp2_lut = 32'd105545;  5'd23: exp2_lut = 32'd107856;
         5'd24: exp2_lut = 32'd110218;  5'd25: exp2_lut = 32'd112631;
         5'd26: exp2_lut = 32'd115098;  5'd27: exp2_lut = 32'd117618;
         5'd28: exp2_lut = 32'd120194;  5'd29: exp2_lut = 32'd122826;
         5'd30: exp2_lut = 32'd125515;  5'd31: exp2_lut = 32'd128263;
         default: exp2_lut = 32'd65536;
      endcase
   endfunction

   // ln(1 + i/32) in Q.16
   function automatic logic [31:0] ln_lut(input logic [4:0] i);
      case (i)
         5'd0:  ln_lut = 32'd0;      5'd1:  ln_lut = 32'd2017;
         5'd2:  ln_lut = 32'd3973;   5'd3:  ln_lut = 32'd5873;
         5'd4:  ln_lut = 32'd7719;   5'd5:  ln_lut = 32'd9515;
         5'd6:  ln_lut = 32'd11262;  5'd7:  ln_lut = 32'd12965;
         5'd8:  ln_lut = 32'd14624;  5'd9:  ln_lut = 32'd16242;
         5'd10: ln_lut = 32'd17822;  5'd11: ln_lut = 32'd19364;
         5'd12: ln_lut = 32'd20870;  5'd13: ln_lut = 32'd22343;
         5'd14: ln_lut = 32'd23783;  5'd15: ln_lut = 32'd25193;
         5'd16: ln_lut = 32'd26573;  5'd17: ln_lut = 32'd27924;
         5'd18: ln_lut = 32'd29248;  5'd19: ln_lut = 32'd30546;
         5'd20: ln_lut = 32'd31818;  5'd21: ln_lut = 32'd33067;
         5'd22: ln_lut = 32'd34292;  5'd23: ln_lut = 32'd35494;
         5'd24: ln_lut = 32'd36675;  5'd25: ln_lut = 32'd37835;
         5'd26: ln_lut = 32'd38975;  5'd27: ln_lut = 32'd40095;
         5'd28: ln_lut = 32'd41197;  5'd29: ln_lut = 32'd42280;
         5'd30: ln_lut = 32'd43345;  5'd31: ln_lut = 32'd44394;
         default: ln_lut = 32'd0;
      endcase
   endfunction

   // Saturate an 18-bit signed difference to Q8.8
   function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
      if (v > 18'sd32767) begin
         sat16 = 16'sh7FFF;
      end else if (v < -18'sd32768) begin
         sat16 = 16'sh8000;
      end else begin
         sat16 = 16'(v);
      end
   endfunction

   function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
      smax = (a > b) ? a : b;
   endfunction

   // exp(x) for x <= 0, Q8.8 in, unsigned Q8.8 out. t = x*log2(e) in Q.16;
   // the 32-entry table is linearly interpolated on the low fraction bits,
   // then the mantissa is shifted right by -floor(t) with rounding.
   function automatic logic [15:0] exp_q88(input logic signed [15:0] x);
      logic signed [15:0] xc;
      logic signed [31:0] t;
      logic [31:0]        nk;
      logic [4:0]         i;
      logic [10:0]        rem;
      logic [31:0]        lo;
      logic [31:0]        hi;
      logic [31:0]        mant;
      logic [31:0]        sh;
      logic [31:0]        val;
      xc   = (x > 16'sd0) ? 16'sd0 : x;
      t    = 32'(xc) * 32'sd369;
      nk   = -(t >>> 5'd16);
      i    = t[15:11];
      rem  = t[10:0];
      lo   = exp2_lut(i);
      hi   = (i == 5'd31) ? 32'd131072 : exp2_lut(i + 5'd1);
      mant = lo + (((hi - lo) * {21'd0, rem}) >> 5'd11);
      sh   = nk + 32'd8;
      val  = (mant + (32'd1 << (sh - 32'd1))) >> sh;
      if (xc < -16'sd2048) begin
         exp_q88 = 16'd0;
      end else begin
         exp_q88 = 16'(val);
      end
   endfunction

   // Position of the most significant set bit (0 when v == 0)
   function automatic logic [4:0] lead_one(input logic [23:0] v);
      logic [4:0] p;
      p = 5'd0;
      for (int b = 0; b < 24; b++) begin
         if (v[b]) begin
            p = 5'(b);
         end else begin
            p = p;
         end
      end
      lead_one = p;
   endfunction

   logic                         clr_s;
   state_t                       state_q, state_d;
   logic [ADDRSIZE-1:0]          cnt_q, cnt_d;
   logic                         issue_q, issue_d;
   logic [1:0]                   drn_q, drn_d;
   logic                         start_ok_s;

   logic signed [DATAWIDTH-1:0]  lmax_s, lmax_q, max_q;
   logic                         lv_q;

   logic signed [DATAWIDTH-1:0]  d_q [NUM];
   logic [DATAWIDTH-1:0]         e_q [NUM];
   logic [DATAWIDTH-1:0]         sum_s, sum_q;
   logic                         v1_q, v2_q, v3_q;
   logic [23:0]                  acc_q;

   logic [4:0]                   p_s, p_adj_s, p_q;
   logic [5:0]                   m6_s;
   logic [6:0]                   idx6_s;
   logic [4:0]                   idx_s, idx_q;
   logic signed [31:0]           lnx_s;
   logic signed [DATAWIDTH-1:0]  ln_s, ln_q;

   logic signed [DATAWIDTH-1:0]  n_q [NUM];
   logic [DATAWIDTH-1:0]         outp_q [NUM];
   logic                         nv_q;
   logic                         done_q;

   assign clr_s      = reset | init;
   assign start_ok_s = (state_q == S_IDLE) & start;

   // Read addresses park on start_addr outside their issuing phase
   assign addr          = (state_q == S_MAX    && issue_q) ? cnt_q : start_addr;
   assign sub0_inp_addr = (state_q == S_EXPSUM && issue_q) ? cnt_q : start_addr;
   assign sub1_inp_addr = (state_q == S_NORM   && issue_q) ? cnt_q : start_addr;

   assign outp0 = outp_q[0];
   assign outp1 = outp_q[1];
   assign outp2 = outp_q[2];
   assign outp3 = outp_q[3];
   assign done  = done_q;

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (clr_s) begin
         state_q <= S_IDLE;
         cnt_q   <= {ADDRSIZE{1'b0}};
         issue_q <= 1'b0;
         drn_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         issue_q <= issue_d;
         drn_q   <= drn_d;
      end
   end

   // Sequencer next state: issue phase walks the range, then a fixed drain
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      issue_d = issue_q;
      drn_d   = drn_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_MAX;
               cnt_d   = start_addr;
               issue_d = 1'b1;
               drn_d   = 2'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MAX: begin
            if (issue_q) begin
               if (cnt_q == end_addr) begin
                  issue_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + ADDRSIZE'(1'b1);
               end
            end else begin
               state_d = S_EXPSUM;
               cnt_d   = start_addr;
               issue_d = 1'b1;
            end
         end
         S_EXPSUM: begin
            if (issue_q) begin
               if (cnt_q == end_addr) begin
                  issue_d = 1'b0;
                  drn_d   = 2'd2;
               end else begin
                  cnt_d = cnt_q + ADDRSIZE'(1'b1);
               end
            end else if (drn_q == 2'd0) begin
               state_d = S_LOG;
               drn_d   = 2'd1;
            end else begin
               drn_d = drn_q - 2'd1;
            end
         end
         S_LOG: begin
            if (drn_q == 2'd0) begin
               state_d = S_NORM;
               cnt_d   = start_addr;
               issue_d = 1'b1;
            end else begin
               drn_d = drn_q - 2'd1;
            end
         end
         S_NORM: begin
            if (issue_q) begin
               if (cnt_q == end_addr) begin
                  issue_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + ADDRSIZE'(1'b1);
               end
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
            issue_d = 1'b0;
            drn_d   = 2'd0;
         end
      endcase
   end

   // Lane max tree and lane adder tree
   always_comb begin
      lmax_s = signed'(inp[DATAWIDTH-1:0]);
      sum_s  = e_q[0];
      for (int i = 1; i < NUM; i++) begin
         lmax_s = smax(lmax_s, signed'(inp[i*DATAWIDTH +: DATAWIDTH]));
         sum_s  = sum_s + e_q[i];
      end
   end

   // MAX pass: registered lane max, then running max
   always_ff @(posedge clk) begin
      if (clr_s) begin
         lv_q   <= 1'b0;
         lmax_q <= 16'sh8000;
         max_q  <= 16'sh8000;
      end else begin
         lv_q   <= (state_q == S_MAX) & issue_q;
         lmax_q <= lmax_s;
         if (start_ok_s) begin
            max_q <= 16'sh8000;
         end else if (lv_q) begin
            max_q <= smax(max_q, lmax_q);
         end else begin
            max_q <= max_q;
         end
      end
   end

   // EXPSUM pass: subtract max, exp, adder tree, accumulate
   always_ff @(posedge clk) begin
      if (clr_s) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         sum_q <= 16'd0;
         acc_q <= 24'd0;
         for (int i = 0; i < NUM; i++) begin
            d_q[i] <= 16'sd0;
            e_q[i] <= 16'd0;
         end
      end else begin
         v1_q  <= (state_q == S_EXPSUM) & issue_q;
         v2_q  <= v1_q;
         v3_q  <= v2_q;
         sum_q <= sum_s;
         for (int i = 0; i < NUM; i++) begin
            d_q[i] <= sat16(18'(signed'(sub0_inp[i*DATAWIDTH +: DATAWIDTH])) - 18'(max_q));
            e_q[i] <= exp_q88(d_q[i]);
         end
         if (start_ok_s) begin
            acc_q <= 24'd0;
         end else if (v3_q) begin
            acc_q <= acc_q + 24'(sum_q);
         end else begin
            acc_q <= acc_q;
         end
      end
   end

   // LOG: normalise the accumulator; the mantissa index is rounded to the
   // nearest table entry, carrying into the exponent at 2.0
   always_comb begin
      p_s    = lead_one(acc_q);
      m6_s   = 6'((acc_q << (5'd23 - p_s)) >> 5'd17);
      idx6_s = (7'(m6_s) + 7'd1) >> 3'd1;
      if (idx6_s == 7'd32) begin
         p_adj_s = p_s + 5'd1;
         idx_s   = 5'd0;
      end else begin
         p_adj_s = p_s;
         idx_s   = 5'(idx6_s);
      end
      lnx_s = (signed'({27'd0, p_q}) - 32'sd8) * 32'sd45426 + signed'(ln_lut(idx_q));
      ln_s  = 16'((lnx_s + 32'sd128) >>> 5'd8);
   end

   // LOG registers: stage 1 captures exponent/index, stage 2 the ln value
   always_ff @(posedge clk) begin
      if (clr_s) begin
         p_q   <= 5'd0;
         idx_q <= 5'd0;
         ln_q  <= 16'sd0;
      end else if (state_q == S_LOG && drn_q == 2'd1) begin
         p_q   <= p_adj_s;
         idx_q <= idx_s;
         ln_q  <= ln_q;
      end else if (state_q == S_LOG && drn_q == 2'd0) begin
         p_q   <= p_q;
         idx_q <= idx_q;
         ln_q  <= ln_s;
      end else if (start_ok_s) begin
         p_q   <= 5'd0;
         idx_q <= 5'd0;
         ln_q  <= 16'sd0;
      end else begin
         p_q   <= p_q;
         idx_q <= idx_q;
         ln_q  <= ln_q;
      end
   end

   // NORM pass: x - max - ln, exp into the output registers; done follows
   // the last word's outputs
   always_ff @(posedge clk) begin
      if (clr_s) begin
         nv_q   <= 1'b0;
         done_q <= 1'b0;
         for (int i = 0; i < NUM; i++) begin
            n_q[i]    <= 16'sd0;
            outp_q[i] <= 16'd0;
         end
      end else begin
         nv_q   <= (state_q == S_NORM) & issue_q;
         done_q <= done_q | ((state_q == S_NORM) & ~issue_q);
         for (int i = 0; i < NUM; i++) begin
            n_q[i] <= sat16(18'(signed'(sub1_inp[i*DATAWIDTH +: DATAWIDTH]))
                            - 18'(max_q) - 18'(ln_q));
            if (nv_q) begin
               outp_q[i] <= exp_q88(n_q[i]);
            end else begin
               outp_q[i] <= outp_q[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_softmax_engine.sv
// Directed bench for softmax_engine: three behavioural combinational-read
// memories share one backing array; expected results are hand-computed
// softmax values with a small tolerance, plus exact pass latency 3*L+7.
module tb_softmax_engine;

   logic        clk = 1'b0;
   logic        reset, init, start;
   logic [7:0]  start_addr, end_addr;
   logic [63:0] inp, sub0_inp, sub1_inp;
   logic [7:0]  addr, sub0_inp_addr, sub1_inp_addr;
   logic [15:0] outp0, outp1, outp2, outp3;
   logic        done;
   logic [63:0] mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign inp      = mem[addr];
   assign sub0_inp = mem[sub0_inp_addr];
   assign sub1_inp = mem[sub1_inp_addr];

   softmax_engine #(.DATAWIDTH(16), .NUM(4), .ADDRSIZE(8)) dut (
      .clk(clk), .reset(reset), .init(init), .start(start),
      .start_addr(start_addr), .end_addr(end_addr),
      .inp(inp), .sub0_inp(sub0_inp), .sub1_inp(sub1_inp),
      .addr(addr), .sub0_inp_addr(sub0_inp_addr), .sub1_inp_addr(sub1_inp_addr),
      .outp0(outp0), .outp1(outp1), .outp2(outp2), .outp3(outp3),
      .done(done)
   );

   task automatic check_val(input string tag, input int got, input int exp, input int tol);
      n_checks++;
      if (got < exp - tol || got > exp + tol) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (+/-%0d)", tag, got, exp, tol);
      end
   endtask

   task automatic clear(input bit use_init);
      @(negedge clk);
      if (use_init) init = 1'b1;
      else          reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      init  = 1'b0;
   endtask

   task automatic check_outs(input string tag, input int e0, input int e1,
                             input int e2, input int e3);
      check_val({tag, "_o0"}, int'(outp0), e0, 4);
      check_val({tag, "_o1"}, int'(outp1), e1, 4);
      check_val({tag, "_o2"}, int'(outp2), e2, 4);
      check_val({tag, "_o3"}, int'(outp3), e3, 4);
      check_val({tag, "_done"}, int'(done), 1, 0);
   endtask

   // One pass; optional second start pulse while in MAX; checks latency
   task automatic run_pass(input logic [7:0] sa, input logic [7:0] ea, input bit dbl,
                           input int exp_lat, input string tag);
      int n;
      start_addr = sa;
      end_addr   = ea;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      check_val({tag, "_addr0"}, int'(addr), int'(sa), 0);
      if (dbl) begin
         @(negedge clk);
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         n = 1;
      end
      while (done !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val({tag, "_lat"}, n, exp_lat, 0);
   endtask

   initial begin
      reset      = 1'b1;
      init       = 1'b0;
      start      = 1'b0;
      start_addr = 8'd5;
      end_addr   = 8'd5;
      for (int i = 0; i < 256; i++) mem[i] = 64'd0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_done", int'(done), 0, 0);
      check_val("rst_o0", int'(outp0), 0, 0);
      check_val("rst_o3", int'(outp3), 0, 0);
      check_val("rst_addr", int'(addr), 5, 0);
      check_val("rst_sub0", int'(sub0_inp_addr), 5, 0);
      check_val("rst_sub1", int'(sub1_inp_addr), 5, 0);
      reset = 1'b0;

      // all-zero word: uniform 0.25
      mem[0] = 64'h0000_0000_0000_0000;
      run_pass(8'd0, 8'd0, 1'b0, 10, "t1");
      check_outs("t1", 'h40, 'h40, 'h40, 'h40);
      repeat (3) @(posedge clk);
      #1;
      check_val("t1_hold_done", int'(done), 1, 0);
      check_val("t1_hold_o1", int'(outp1), 'h40, 4);
      // start in DONE is ignored
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_val("t1_ign_addr", int'(addr), 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_val("t1_ign_done", int'(done), 1, 0);
      check_val("t1_ign_o2", int'(outp2), 'h40, 4);
      clear(1'b1);
      check_val("init_done", int'(done), 0, 0);
      check_val("init_o0", int'(outp0), 0, 0);

      // two words of 1.0: eight equal elements
      mem[0] = 64'h0100_0100_0100_0100;
      mem[1] = 64'h0100_0100_0100_0100;
      run_pass(8'd0, 8'd1, 1'b0, 13, "t2");
      check_outs("t2", 'h20, 'h20, 'h20, 'h20);
      clear(1'b0);

      // one dominant lane
      mem[0] = 64'h0000_0000_0000_0400;
      run_pass(8'd0, 8'd0, 1'b0, 10, "t3");
      check_outs("t3", 'hF3, 'h04, 'h04, 'h04);
      clear(1'b1);

      // lane 3 far below the rest
      mem[0] = 64'hF000_0000_0000_0000;
      run_pass(8'd0, 8'd0, 1'b0, 10, "t4");
      check_outs("t4", 'h55, 'h55, 'h55, 'h00);
      clear(1'b0);

      // reset during EXPSUM, then a full pass
      mem[10] = 64'h0100_0100_0100_0100;
      mem[11] = 64'h0100_0100_0100_0100;
      start_addr = 8'd10;
      end_addr   = 8'd11;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_val("t5_mid_sub0", int'(sub0_inp_addr), 11, 0);
      check_val("t5_mid_addr", int'(addr), 10, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("t5_abort_done", int'(done), 0, 0);
      check_val("t5_abort_o0", int'(outp0), 0, 0);
      check_val("t5_abort_sub0", int'(sub0_inp_addr), 10, 0);
      check_val("t5_abort_sub1", int'(sub1_inp_addr), 10, 0);
      reset = 1'b0;
      run_pass(8'd10, 8'd11, 1'b0, 13, "t5");
      check_outs("t5", 'h20, 'h20, 'h20, 'h20);
      clear(1'b1);

      // second start pulse during MAX is ignored
      run_pass(8'd10, 8'd11, 1'b1, 13, "t6");
      check_outs("t6", 'h20, 'h20, 'h20, 'h20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/softmax_engine.md
SOFTMAX_ENGINE -- requirements
Module: softmax

Interface
REQ-001 SHALL have parameter DATAWIDTH, 16, bits per element (signed two's-complement Q8.8).
REQ-002 SHALL have parameter NUM, 4, elements per memory word (lanes); lane i occupies bits [16i+15:16i].
REQ-003 SHALL have parameter ADDRSIZE, 8, memory address width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port init, input, 1, synchronous clear with the same effect as reset.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins a softmax pass.
REQ-008 SHALL have ports start_addr and end_addr, input, ADDRSIZE, inclusive word range (end_addr >= start_addr).
REQ-009 SHALL have ports inp, sub0_inp and sub1_inp, input, DATAWIDTH*NUM, read data of three identical memories with combinational read (data valid in the same cycle as the address).
REQ-010 SHALL have ports addr, sub0_inp_addr and sub1_inp_addr, output, ADDRSIZE, read addresses for those memories.
REQ-011 SHALL have ports outp0..outp(NUM-1), output, DATAWIDTH, softmax result per lane, Q8.8.
REQ-012 SHALL have port done, output, 1, pass complete.

Function
REQ-013 SHALL compute outp = exp(x - max - ln(sum(exp(x_j - max)))) over all NUM*(end_addr-start_addr+1) elements.
REQ-014 SHALL implement FSM IDLE -> MAX -> EXPSUM -> LOG -> NORM -> DONE; the start pulse is accepted only in IDLE and ignored in every other state.
REQ-015 MAX: addr steps start_addr..end_addr, one word per cycle; lane max tree feeds running-max register (initialised to 0x8000); 1 drain cycle after the last word.
REQ-016 EXPSUM: sub0_inp_addr steps start_addr..end_addr; pipeline: subtract max (reg), exp (reg), lane adder tree into 24-bit unsigned accumulator with 8 fraction bits; 3 drain cycles after the last word.
REQ-017 Exp unit: input <= 0 Q8.8; input < -8.0 gives 0; otherwise t = x*log2(e), integer part k, 2^frac(t) from a 32-entry LUT, result shifted right by -k; Q8.8 unsigned; max abs error 2^-7.
REQ-018 LOG: 2 cycles; leading-one position p of the accumulator, ln = (p-8)*ln2 + ln(mantissa) from a 32-entry LUT; Q8.8 signed; max abs error 2^-7.
REQ-019 NORM: sub1_inp_addr steps start_addr..end_addr; pipeline: x - max - ln (saturating Q8.8, reg), exp (reg) drives outp registers; outputs for word a appear 2 cycles after sub1_inp_addr = a.
REQ-020 All subtractions SHALL saturate to 0x8000/0x7FFF; the accumulator SHALL not wrap for ranges up to 2^ADDRSIZE words.
REQ-021 done SHALL rise in the cycle the last word's outputs appear and hold, with the outputs, until reset/init.
REQ-022 Address outputs SHALL equal start_addr when their phase is inactive.
REQ-023 Single-word range (start_addr = end_addr) SHALL work with identical pipeline timing.

Reset
REQ-024 On reset or init: FSM IDLE; done = 0; outp* = 0; running max = 0x8000; accumulator and log register = 0; address outputs = start_addr.
REQ-025 Reset asserted mid-pass SHALL abort the pass in the next cycle; a new start after reset SHALL run a full pass.

Verification
REQ-026 One word {0,0,0,0}, start_addr = end_addr = 0 -> every outp 0x0040 (0.25) within ±4 LSB; done set.
REQ-027 Words 0..1 all 0x0100 (1.0) -> max 0x0100, every outp 0x0020 (0.125) within ±4 LSB.
REQ-028 One word {0x0400,0,0,0} -> outp0 0x00F3 (0.948), outp1..3 0x0004 within ±4 LSB.
REQ-029 One word {0,0,0,0xF000 (-16.0)} -> outp0..2 0x0055 within ±4 LSB, outp3 0x0000.
REQ-030 Reset asserted during EXPSUM -> next cycle done = 0, outp* = 0, addresses = start_addr; a following start completes correctly.
REQ-031 Second start pulse during MAX -> ignored; results and done timing identical to a single pulse.
